alu_multicycle: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU, for the EX stage of the LEGv8 pipeline.
- Widens the op set:
  - arithmetic shift right, MUL, UDIV, SDIV;
  - full NZCV flags.
- Single-cycle ops finish in one cycle. MUL/DIV run iteratively over WIDTH cycles.
- Uses a valid/ready handshake on input and output, so the hazard unit can stall the pipeline while a long op is in flight.

---
 rtl/alu_multicycle_pkg.sv | 39 +++
 rtl/alu_iter_muldiv.sv | 120 ++++++++++++
 rtl/alu_multicycle.sv | 148 ++++++++++++++
 tb/tb_alu_multicycle.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle EX-stage ALU.
//   - alu_op_e   : 4-bit ALUCtrl operation codes
//   - state_e    : top-level handshake FSM states
//   - md_mode_e  : operation selector for the iterative mul/div unit
//   - FLAG_*     : bit positions inside the {N,Z,C,V} flags vector
package alu_multicycle_pkg;

    typedef enum logic [3:0] {
        ALU_AND          = 4'b0000,
        ALU_OR           = 4'b0001,
        ALU_ADD          = 4'b0010,
        ALU_XOR          = 4'b0011,
        ALU_LSHIFT_LEFT  = 4'b0100,
        ALU_LSHIFT_RIGHT = 4'b0101,
        ALU_SUB          = 4'b0110,
        ALU_ASHIFT_RIGHT = 4'b0111,
        ALU_MUL          = 4'b1000,
        ALU_UDIV         = 4'b1001,
        ALU_SDIV         = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_UDIV = 2'd1,
        MD_SDIV = 2'd2
    } md_mode_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply / divide engine, one bit per clock.
//   clk, reset : clock, synchronous active-high reset (aborts a running op)
//   start      : one-cycle pulse; loads a, b, mode and begins WIDTH iterations
//   mode       : md_mode_e (MUL, UDIV, SDIV)
//   a, b       : operands, sampled only on start
//   done       : high during the cycle whose clock edge performs the last iteration
//   q          : result of that last iteration (combinational, valid while done=1)
// Division by zero is never started here; the top handles it.
module alu_iter_muldiv
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] q
);
    localparam int CW = $clog2(WIDTH);

    // MUL : ra = shifted multiplicand, rb = shifted multiplier, rr = product
    // DIV : ra = dividend shifting out / quotient shifting in, rb = divisor,
    //       rr = partial remainder
    logic             run_q, run_d;
    logic             mul_q, mul_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rr_q, rr_d;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic             a_neg;
    logic             b_neg;

    always_comb begin
        run_d = run_q;
        mul_d = mul_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        rr_d  = rr_q;

        // Next values of one iteration, shared by the update and by q.
        mul_acc  = rr_q + (rb_q[0] ? ra_q : '0);
        div_sh   = {rr_q, ra_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, rb_q};
        // Remainder < divisor keeps div_sh < 2*divisor, so the top bit of the
        // difference is a clean "did not fit" indicator.
        div_ok   = ~div_diff[WIDTH];
        div_rem  = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo  = {ra_q[WIDTH-2:0], div_ok};

        a_neg = (mode == MD_SDIV) && a[WIDTH-1];
        b_neg = (mode == MD_SDIV) && b[WIDTH-1];

        if (start) begin
            run_d = 1'b1;
            cnt_d = CW'(WIDTH - 1);
            mul_d = (mode == MD_MUL);
            rr_d  = '0;
            if (mode == MD_MUL) begin
                ra_d  = a;
                rb_d  = b;
                neg_d = 1'b0;
            end else begin
                // SDIV divides magnitudes; MIN_INT's magnitude is still
                // correct when read as unsigned.
                ra_d  = a_neg ? -a : a;
                rb_d  = b_neg ? -b : b;
                neg_d = a_neg ^ b_neg;
            end
        end else if (run_q) begin
            if (mul_q) begin
                rr_d = mul_acc;
                ra_d = ra_q << 1;
                rb_d = rb_q >> 1;
            end else begin
                rr_d = div_rem;
                ra_d = div_quo;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) run_d = 1'b0;
        end
    end

    assign done = run_q && (cnt_q == '0);
    assign q    = mul_q ? mul_acc : (neg_q ? -div_quo : div_quo);

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            mul_q <= 1'b0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rr_q  <= '0;
        end else begin
            run_q <= run_d;
            mul_q <= mul_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            ra_q  <= ra_d;
            rb_q  <= rb_d;
            rr_q  <= rr_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU with valid/ready handshakes.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (A, B, ALUCtrl)
//   out_valid/out_ready : result handshake (result, flags {N,Z,C,V})
//   busy                : high while an iterative MUL/DIV is in flight
// Single-cycle ops and divide-by-zero register their result on the accept
// edge; MUL/UDIV/SDIV spend WIDTH cycles in BUSY inside alu_iter_muldiv.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCtrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             is_iter;
    logic [1:0]       md_mode;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_q;
    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;

    // Single-cycle datapath, evaluated on the live inputs so the result can
    // be captured on the accept edge.
    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        is_iter = 1'b0;
        md_mode = MD_MUL;
        shamt   = B[SHW-1:0];
        // One adder serves ADD and SUB (A + ~B + 1).
        bop     = (ALUCtrl == ALU_SUB) ? ~B : B;
        sum     = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, (ALUCtrl == ALU_SUB)};
        case (ALUCtrl)
            ALU_AND:          sc_res = A & B;
            ALU_OR:           sc_res = A | B;
            ALU_XOR:          sc_res = A ^ B;
            ALU_ADD, ALU_SUB: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (A[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_LSHIFT_LEFT:  sc_res = A << shamt;
            ALU_LSHIFT_RIGHT: sc_res = A >> shamt;
            ALU_ASHIFT_RIGHT: sc_res = $signed(A) >>> shamt;
            ALU_MUL:          is_iter = 1'b1;
            ALU_UDIV: begin
                // Zero divisor falls through with sc_res = 0 in one cycle.
                is_iter = (B != '0);
                md_mode = MD_UDIV;
            end
            ALU_SDIV: begin
                is_iter = (B != '0);
                md_mode = MD_SDIV;
            end
            default:          sc_res = '0;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (md_start),
        .mode  (md_mode),
        .a     (A),
        .b     (B),
        .done  (md_done),
        .q     (md_q)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        md_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter) begin
                        md_start = 1'b1;
                        state_d  = ST_BUSY;
                    end else begin
                        result_d         = sc_res;
                        flags_d[FLAG_N]  = sc_res[WIDTH-1];
                        flags_d[FLAG_Z]  = (sc_res == '0);
                        flags_d[FLAG_C]  = sc_c;
                        flags_d[FLAG_V]  = sc_v;
                        state_d          = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    result_d         = md_q;
                    flags_d[FLAG_N]  = md_q[WIDTH-1];
                    flags_d[FLAG_Z]  = (md_q == '0);
                    flags_d[FLAG_C]  = 1'b0;
                    flags_d[FLAG_V]  = 1'b0;
                    state_d          = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench: a WIDTH=64 instance driven by directed and random ops
// against a behavioural reference, plus a WIDTH=8 instance for back-pressure.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=64 instance
    logic        rst64, iv64, ir64, ov64, or64, busy64;
    logic [63:0] a64, b64, res64;
    logic [3:0]  op64, fl64;
    // WIDTH=8 instance
    logic        rst8, iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8, fl8;

    alu_multicycle #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(rst64), .in_valid(iv64), .in_ready(ir64),
        .A(a64), .B(b64), .ALUCtrl(op64), .out_valid(ov64), .out_ready(or64),
        .result(res64), .flags(fl64), .busy(busy64));

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .ALUCtrl(op8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .flags(fl8), .busy(busy8));

    int n_cmp = 0;
    int n_err = 0;
    logic [67:0] sb64[$];
    logic [11:0] sb8[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural reference: {result, N, Z, C, V}
    function automatic logic [67:0] model64(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic [64:0] s;
        logic        c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd3: r = a ^ b;
            4'd2: begin
                r = a + b;
                s = {1'b0, a} + {1'b0, b};
                c = s[64];
                s = {a[63], a} + {b[63], b};
                v = s[64] ^ s[63];
            end
            4'd6: begin
                r = a - b;
                c = (a >= b);
                s = {a[63], a} - {b[63], b};
                v = s[64] ^ s[63];
            end
            4'd4: r = a << b[5:0];
            4'd5: r = a >> b[5:0];
            4'd7: r = $signed(a) >>> b[5:0];
            4'd8: r = a * b;
            4'd9: r = (b == 0) ? 64'd0 : a / b;
            4'd10: begin
                if (b == 0) r = '0;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            default: r = '0;
        endcase
        return {r, r[63], (r == 0), c, v};
    endfunction

    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r_o, output logic [3:0] f_o);
        int lat, nbusy, exp_lat;
        logic [67:0] e;
        exp_lat = (op == ALU_MUL || ((op == ALU_UDIV || op == ALU_SDIV) && b != 0)) ? 65 : 1;
        sb64.push_back(model64(op, a, b));
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(ir64), 64'd1);
        a64 = a; b64 = b; op64 = op; iv64 = 1'b1;
        @(posedge clk);
        #1 iv64 = 1'b0;
        lat = 1; nbusy = 0;
        @(negedge clk);
        while (!ov64 && lat < 200) begin
            if (busy64) nbusy++;
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        e = sb64.pop_front();
        chk({tag, " result"}, res64, e[67:4]);
        chk({tag, " flags"}, 64'(fl64), 64'(e[3:0]));
        r_o = res64; f_o = fl64;
        or64 = 1'b1;
        @(posedge clk);
        #1 or64 = 1'b0;
        @(negedge clk);
        chk({tag, " in_ready_after"}, 64'(ir64), 64'd1);
    endtask

    task automatic do8(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef, input int elat, input int hold);
        int lat;
        logic [11:0] e;
        sb8.push_back({er, ef});
        @(negedge clk);
        a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
        @(posedge clk);
        #1 iv8 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov8 && lat < 50) begin lat++; @(negedge clk); end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        e = sb8.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold result"}, 64'(res8), 64'(e[11:4]));
            chk({tag, " hold flags"}, 64'(fl8), 64'(e[3:0]));
            chk({tag, " hold in_ready"}, 64'(ir8), 64'd0);
            chk({tag, " hold out_valid"}, 64'(ov8), 64'd1);
            @(negedge clk);
        end
        chk({tag, " result"}, 64'(res8), 64'(e[11:4]));
        chk({tag, " flags"}, 64'(fl8), 64'(e[3:0]));
        chk({tag, " in_ready before"}, 64'(ir8), 64'd0);
        or8 = 1'b1;
        @(posedge clk);
        #1 or8 = 1'b0;
        @(negedge clk);
        chk({tag, " in_ready after"}, 64'(ir8), 64'd1);
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0]  f;
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        rst64 = 1'b1; iv64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0; op64 = '0;
        rst8  = 1'b1; iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
        repeat (3) @(negedge clk);
        rst64 = 1'b0; rst8 = 1'b0;
        chk("rst in_ready", 64'(ir64), 64'd1);
        chk("rst out_valid", 64'(ov64), 64'd0);
        chk("rst busy", 64'(busy64), 64'd0);
        chk("rst result", res64, 64'd0);
        chk("rst flags", 64'(fl64), 64'd0);
        chk("rst8 in_ready", 64'(ir8), 64'd1);

        // Reset while a MUL is 10 cycles in: aborted, no output.
        @(negedge clk);
        a64 = 64'd7; b64 = 64'd9; op64 = ALU_MUL; iv64 = 1'b1;
        @(posedge clk);
        #1 iv64 = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid busy", 64'(busy64), 64'd1);
        rst64 = 1'b1;
        @(negedge clk);
        rst64 = 1'b0;
        chk("abort out_valid", 64'(ov64), 64'd0);
        chk("abort in_ready", 64'(ir64), 64'd1);
        chk("abort busy", 64'(busy64), 64'd0);
        do_op("add after abort", ALU_ADD, 64'd1, 64'd1, r, f);
        chk("add after abort const", r, 64'd2);

        do_op("sub eq", ALU_SUB, 64'd5, 64'd5, r, f);
        chk("sub eq const", r, 64'd0);
        chk("sub eq flags const", 64'(f), 64'b0110);
        do_op("sub neg", ALU_SUB, 64'd3, 64'd5, r, f);
        chk("sub neg const", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub neg flags const", 64'(f), 64'b1000);
        do_op("add ovf", ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, r, f);
        chk("add ovf const", r, 64'h8000_0000_0000_0000);
        chk("add ovf flags const", 64'(f), 64'b1001);
        do_op("mul", ALU_MUL, 64'h1_0000_0001, 64'd3, r, f);
        chk("mul const", r, 64'h3_0000_0003);
        do_op("sdiv", ALU_SDIV, -64'd7, 64'd2, r, f);
        chk("sdiv const", r, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("sdiv N const", 64'(f[3]), 64'd1);
        do_op("udiv0", ALU_UDIV, 64'd9, 64'd0, r, f);
        chk("udiv0 flags const", 64'(f), 64'b0100);
        do_op("sdiv min", ALU_SDIV, 64'h8000_0000_0000_0000, '1, r, f);
        chk("sdiv min const", r, 64'h8000_0000_0000_0000);
        chk("sdiv min flags const", 64'(f), 64'b1000);
        do_op("asr", ALU_ASHIFT_RIGHT, 64'h8000_0000_0000_0000, 64'h43, r, f);
        chk("asr const", r, 64'hF000_0000_0000_0000);
        do_op("udiv", ALU_UDIV, 64'd1000, 64'd7, r, f);
        do_op("sdiv0", ALU_SDIV, -64'd5, 64'd0, r, f);
        do_op("unknown", 4'b1101, 64'd12, 64'd34, r, f);
        chk("unknown flags const", 64'(f), 64'b0100);

        for (int i = 0; i < 14; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = {$urandom, $urandom};
            rb  = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (i % 4 == 1) rb = -rb;
            do_op($sformatf("rnd%0d op%0d", i, rop), rop, ra, rb, r, f);
        end

        do8("w8 add hold", ALU_ADD, 8'd200, 8'd100, 8'd44, 4'b0010, 1, 5);
        do8("w8 mul", ALU_MUL, 8'd15, 8'd17, 8'd255, 4'b1000, 9, 0);
        do8("w8 sdiv", ALU_SDIV, 8'hF9, 8'd2, 8'hFD, 4'b1000, 9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
